// File: rtl/lcd_frame_refresher.sv
// Character frame buffer that streams its contents to an HD44780-style LCD controller:
// the init command set once after reset, then per row an address command and that row's characters.
module lcd_frame_refresher #(
    parameter int ROWS       = 2,
    parameter int COLS       = 16,
    parameter int DLY_CYCLES = 262142,
    parameter int CONTINUOUS = 0,
    parameter int AW         = 7
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iWE,
    input  logic [AW-1:0] iWADDR,
    input  logic [7:0]    iWDATA,
    input  logic          iREFRESH,
    output logic          oBUSY,
    output logic          oFRAME_DONE,
    output logic [7:0]    oLCD_DATA,
    output logic          oLCD_RS,
    output logic          oLCD_START,
    input  logic          iLCD_DONE
);

    localparam int DEPTH = ROWS * COLS;
    localparam int BW    = $clog2(DEPTH);
    localparam int IW    = $clog2(COLS);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (DLY_CYCLES > 0) ? $clog2(DLY_CYCLES + 1) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ROWCMD, S_CHARS, S_FIN} top_t;
    typedef enum logic [1:0] {M_LOAD, M_WAIT, M_DLY, M_NEXT} mst_t;

    top_t          top_q, top_d;
    mst_t          mst_q, mst_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          start_q, start_d;
    logic          init_done_q, init_done_d;
    logic          dirty_q, dirty_d;
    logic          pend_q, pend_d;
    logic          busy_q, busy_d;
    logic          fdone_q, fdone_d;

    logic [7:0]    fbuf [DEPTH];
    logic          wr_ok;
    logic [BW-1:0] rd_addr;
    logic [7:0]    row_base;
    logic [7:0]    ld_byte;
    logic          ld_rs;

    assign wr_ok    = iWE && ({1'b0, iWADDR} < DEPTH_W);
    assign rd_addr  = BW'(row_q) * BW'(COLS) + BW'(idx_q);
    // Rows 2/3 continue rows 0/1 in DDRAM, one row-width further on
    assign row_base = (row_q[0] ? 8'h40 : 8'h00) + ((32'(row_q) >= 32'd2) ? 8'(COLS) : 8'h00);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < DEPTH; i++) fbuf[i] <= 8'h20;
        end else if (wr_ok) begin
            fbuf[iWADDR[BW-1:0]] <= iWDATA;
        end
    end

    always_comb begin
        ld_byte = 8'h00;
        ld_rs   = 1'b0;
        case (top_q)
            S_INIT: begin
                case (idx_q[1:0])
                    2'd0:    ld_byte = 8'h38;
                    2'd1:    ld_byte = 8'h0C;
                    2'd2:    ld_byte = 8'h01;
                    default: ld_byte = 8'h06;
                endcase
            end
            S_ROWCMD: ld_byte = 8'h80 | row_base;
            S_CHARS: begin
                ld_byte = fbuf[rd_addr];
                ld_rs   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        top_d       = top_q;
        mst_d       = mst_q;
        idx_d       = idx_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        rs_d        = rs_q;
        start_d     = start_q;
        init_done_d = init_done_q;
        dirty_d     = dirty_q;
        pend_d      = pend_q;

        if (iREFRESH && top_q != S_IDLE) pend_d = 1'b1;

        case (top_q)
            S_IDLE: begin
                if ((iREFRESH || dirty_q) && init_done_q) begin
                    top_d = S_ROWCMD;
                    row_d = '0;
                    idx_d = '0;
                    mst_d = M_LOAD;
                end
            end
            S_FIN: begin
                // A request arriving in this very cycle is folded into the decision
                pend_d = 1'b0;
                row_d  = '0;
                idx_d  = '0;
                mst_d  = M_LOAD;
                if (CONTINUOUS != 0 || dirty_q || pend_q || iREFRESH) top_d = S_ROWCMD;
                else                                                  top_d = S_IDLE;
            end
            default: begin
                case (mst_q)
                    M_LOAD: begin
                        data_d  = ld_byte;
                        rs_d    = ld_rs;
                        start_d = 1'b1;
                        mst_d   = M_WAIT;
                        if (top_q == S_ROWCMD && row_q == '0) dirty_d = 1'b0;
                    end
                    M_WAIT: begin
                        if (iLCD_DONE) begin
                            start_d = 1'b0;
                            cnt_d   = '0;
                            mst_d   = (DLY_CYCLES == 0) ? M_NEXT : M_DLY;
                        end
                    end
                    M_DLY: begin
                        if (cnt_q == CW'(DLY_CYCLES - 1)) mst_d = M_NEXT;
                        else                              cnt_d = cnt_q + 1'b1;
                    end
                    default: begin
                        mst_d = M_LOAD;
                        case (top_q)
                            S_INIT: begin
                                if (idx_q == IW'(3)) begin
                                    idx_d       = '0;
                                    row_d       = '0;
                                    init_done_d = 1'b1;
                                    top_d       = S_ROWCMD;
                                end else begin
                                    idx_d = idx_q + 1'b1;
                                end
                            end
                            S_ROWCMD: begin
                                idx_d = '0;
                                top_d = S_CHARS;
                            end
                            default: begin
                                if (idx_q == IW'(COLS - 1)) begin
                                    idx_d = '0;
                                    if (row_q == RW'(ROWS - 1)) begin
                                        top_d = S_FIN;
                                    end else begin
                                        row_d = row_q + 1'b1;
                                        top_d = S_ROWCMD;
                                    end
                                end else begin
                                    idx_d = idx_q + 1'b1;
                                end
                            end
                        endcase
                    end
                endcase
            end
        endcase

        // A write landing in the row-0 command cycle must still force another pass
        if (wr_ok) dirty_d = 1'b1;

        busy_d  = (top_d != S_IDLE);
        fdone_d = (top_d == S_FIN);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            top_q       <= S_INIT;
            mst_q       <= M_LOAD;
            idx_q       <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            start_q     <= 1'b0;
            init_done_q <= 1'b0;
            dirty_q     <= 1'b1;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            fdone_q     <= 1'b0;
        end else begin
            top_q       <= top_d;
            mst_q       <= mst_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            start_q     <= start_d;
            init_done_q <= init_done_d;
            dirty_q     <= dirty_d;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            fdone_q     <= fdone_d;
        end
    end

    assign oBUSY       = busy_q;
    assign oFRAME_DONE = fdone_q;
    assign oLCD_DATA   = data_q;
    assign oLCD_RS     = rs_q;
    assign oLCD_START  = start_q;

endmodule

// File: tb/tb_lcd_frame_refresher.sv
// Bench for lcd_frame_refresher: a 2x16 instance with a 3-cycle controller model, and a
// 4x20 continuous instance with zero post-transfer delay.
module tb_lcd_frame_refresher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we;
    logic [6:0] waddr;
    logic [7:0] wdata;
    logic       refresh;

    logic       busy, fdone, lrs, lstart, done;
    logic [7:0] ldata;
    logic       busy4, fdone4, lrs4, lstart4, done4;
    logic [7:0] ldata4;
    logic       we4 = 1'b0;
    logic [6:0] waddr4 = 7'd0;
    logic [7:0] wdata4 = 8'd0;
    logic       refresh4 = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [8:0] cap[$];
    logic [8:0] cap4[$];
    logic [8:0] exp_q[$];
    logic [7:0] mbuf[80];
    int frames = 0, frames4 = 0, gaps4 = 0;
    int act_c = 0, act_c4 = 0;
    bit act = 1'b0, act4 = 1'b0;
    int rd1 = 0;

    always #5 clk = ~clk;

    lcd_frame_refresher #(.ROWS(2), .COLS(16), .DLY_CYCLES(4), .CONTINUOUS(0), .AW(7)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iWE(we), .iWADDR(waddr), .iWDATA(wdata),
        .iREFRESH(refresh), .oBUSY(busy), .oFRAME_DONE(fdone), .oLCD_DATA(ldata),
        .oLCD_RS(lrs), .oLCD_START(lstart), .iLCD_DONE(done));

    lcd_frame_refresher #(.ROWS(4), .COLS(20), .DLY_CYCLES(0), .CONTINUOUS(1), .AW(7)) dut4 (
        .iCLK(clk), .iRST_N(rst_n), .iWE(we4), .iWADDR(waddr4), .iWDATA(wdata4),
        .iREFRESH(refresh4), .oBUSY(busy4), .oFRAME_DONE(fdone4), .oLCD_DATA(ldata4),
        .oLCD_RS(lrs4), .oLCD_START(lstart4), .iLCD_DONE(done4));

    // Controller models: capture the byte when start is first seen, answer done 3 cycles later
    always @(negedge clk) begin
        if (!rst_n) begin
            act = 1'b0; done = 1'b0;
        end else begin
            if (fdone) frames++;
            if (!lstart) begin
                act = 1'b0; done = 1'b0;
            end else if (!act) begin
                act = 1'b1; act_c = 0; cap.push_back({lrs, ldata});
            end else begin
                act_c++; done = (act_c == 2);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            act4 = 1'b0; done4 = 1'b0;
        end else begin
            if (fdone4) frames4++;
            if (frames4 >= 1 && frames4 < 3 && !busy4) gaps4++;
            if (!lstart4) begin
                act4 = 1'b0; done4 = 1'b0;
            end else if (!act4) begin
                act4 = 1'b1; act_c4 = 0; cap4.push_back({lrs4, ldata4});
            end else begin
                act_c4++; done4 = (act_c4 == 2);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected byte stream of one pass, from the display's addressing rules
    function automatic void build_exp(input bit with_init, input int nr, input int nc, input bit blank);
        exp_q.delete();
        if (with_init) begin
            exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
            exp_q.push_back(9'h001); exp_q.push_back(9'h006);
        end
        for (int r = 0; r < nr; r++) begin
            exp_q.push_back(9'h080 + 9'((r % 2) * 64 + (r / 2) * nc));
            for (int c = 0; c < nc; c++)
                exp_q.push_back({1'b1, blank ? 8'h20 : mbuf[r * nc + c]});
        end
    endfunction

    task automatic wait_frame(input int target, output bit ok);
        int n = 0;
        while (frames < target && n < 4000) begin
            @(negedge clk); n++;
        end
        ok = (frames >= target);
        @(negedge clk);
    endtask

    task automatic do_write(input int a, input logic [7:0] d);
        @(negedge clk); we = 1'b1; waddr = 7'(a); wdata = d;
        @(negedge clk); we = 1'b0;
        if (a < 32) mbuf[a] = d;
    endtask

    task automatic pulse_refresh();
        @(negedge clk); refresh = 1'b1;
        @(negedge clk); refresh = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 80; i++) mbuf[i] = 8'h20;
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; refresh = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (fdone !== 1'b0) begin errors++; $display("FAIL rst_fdone got %b want 0", fdone); end
        checks++; if (ldata !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", ldata); end
        checks++; if (lrs !== 1'b0) begin errors++; $display("FAIL rst_rs got %b want 0", lrs); end
        checks++; if (lstart !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", lstart); end
        checks++; if ({busy4, lstart4} !== 2'b00) begin errors++; $display("FAIL rst_dut4 got %b want 00", {busy4, lstart4}); end
        rst_n = 1'b1;
    endtask

    task automatic test_init_pass();
        bit ok;
        logic [8:0] got;
        wait_frame(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL init_pass_timeout frames %0d want 1", frames); end
        build_exp(1, 2, 16, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (rd1 + i < cap.size()) ? cap[rd1 + i] : 9'h1FF;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL init_byte[%0d] got %h want %h", i, got, exp_q[i]); end
        end
        rd1 += exp_q.size();
        repeat (60) @(negedge clk);
        checks++; if (frames !== 1) begin errors++; $display("FAIL init_frame_count got %0d want 1", frames); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_idle_busy got %b want 0", busy); end
        checks++; if (cap.size() !== rd1) begin errors++; $display("FAIL init_extra_bytes got %0d want %0d", cap.size(), rd1); end
    endtask

    task automatic test_continuous();
        int n = 0;
        logic [8:0] got;
        logic [8:0] rowcmd [4];
        rowcmd[0] = 9'h080; rowcmd[1] = 9'h0C0; rowcmd[2] = 9'h094; rowcmd[3] = 9'h0D4;
        while (frames4 < 3 && n < 6000) begin @(negedge clk); n++; end
        checks++; if (frames4 < 3) begin errors++; $display("FAIL cont_timeout frames %0d want 3", frames4); end
        build_exp(1, 4, 20, 1);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < cap4.size()) ? cap4[i] : 9'h1FF;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL cont_pass1[%0d] got %h want %h", i, got, exp_q[i]); end
        end
        for (int r = 0; r < 4; r++) begin
            got = (4 + 21 * r < cap4.size()) ? cap4[4 + 21 * r] : 9'h1FF;
            checks++; if (got !== rowcmd[r]) begin errors++; $display("FAIL cont_rowcmd%0d got %h want %h", r, got, rowcmd[r]); end
        end
        build_exp(0, 4, 20, 1);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (88 + i < cap4.size()) ? cap4[88 + i] : 9'h1FF;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL cont_pass2[%0d] got %h want %h", i, got, exp_q[i]); end
        end
        checks++; if (gaps4 !== 0) begin errors++; $display("FAIL cont_busy_gap got %0d want 0", gaps4); end
    endtask

    task automatic test_write_idle();
        bit ok;
        int f0 = frames;
        logic [8:0] got;
        do_write(17, 8'h41);
        wait_frame(f0 + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL widle_timeout frames %0d want %0d", frames, f0 + 1); end
        build_exp(0, 2, 16, 0);
        got = (rd1 + 19 < cap.size()) ? cap[rd1 + 19] : 9'h1FF;
        checks++; if (got !== 9'h141) begin errors++; $display("FAIL widle_char got %h want 141", got); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (rd1 + i < cap.size()) ? cap[rd1 + i] : 9'h1FF;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL widle_byte[%0d] got %h want %h", i, got, exp_q[i]); end
        end
        rd1 += exp_q.size();
        repeat (60) @(negedge clk);
        checks++; if (frames !== f0 + 1 || busy !== 1'b0) begin errors++; $display("FAIL widle_end frames %0d busy %b want %0d 0", frames, busy, f0 + 1); end
    endtask

    task automatic test_random_writes();
        bit ok;
        int a, f0;
        logic [7:0] d;
        logic [8:0] got;
        for (int k = 0; k < 6; k++) begin
            a = $urandom_range(0, 47);
            d = 8'($urandom_range(33, 126));
            f0 = frames;
            do_write(a, d);
            if (a < 32) begin
                wait_frame(f0 + 1, ok);
                checks++; if (!ok) begin errors++; $display("FAIL rnd_timeout addr %0d frames %0d", a, frames); end
                build_exp(0, 2, 16, 0);
                for (int i = 0; i < exp_q.size(); i++) begin
                    got = (rd1 + i < cap.size()) ? cap[rd1 + i] : 9'h1FF;
                    checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL rnd_byte[%0d] addr %0d got %h want %h", i, a, got, exp_q[i]); end
                end
                rd1 += exp_q.size();
                repeat (60) @(negedge clk);
                checks++; if (frames !== f0 + 1 || busy !== 1'b0) begin errors++; $display("FAIL rnd_end frames %0d busy %b want %0d 0", frames, busy, f0 + 1); end
            end else begin
                repeat (100) @(negedge clk);
                checks++; if (frames !== f0 || cap.size() !== rd1) begin errors++; $display("FAIL rnd_oor addr %0d frames %0d bytes %0d want %0d %0d", a, frames, cap.size(), f0, rd1); end
            end
        end
    endtask

    task automatic test_write_during_pass();
        bit ok;
        int n = 0;
        int f0 = frames;
        logic [8:0] got;
        pulse_refresh();
        while (cap.size() < rd1 + 3 && n < 500) begin @(negedge clk); n++; end
        do_write(20, 8'h5A);
        wait_frame(f0 + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wpass_timeout frames %0d want %0d", frames, f0 + 1); end
        got = (rd1 + 22 < cap.size()) ? cap[rd1 + 22] : 9'h1FF;
        checks++; if (got !== 9'h15A) begin errors++; $display("FAIL wpass_char got %h want 15A", got); end
        for (int p = 0; p < 2; p++) begin
            if (p == 1) begin
                wait_frame(f0 + 2, ok);
                checks++; if (!ok) begin errors++; $display("FAIL wpass_extra_timeout frames %0d want %0d", frames, f0 + 2); end
            end
            build_exp(0, 2, 16, 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                got = (rd1 + i < cap.size()) ? cap[rd1 + i] : 9'h1FF;
                checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL wpass%0d_byte[%0d] got %h want %h", p, i, got, exp_q[i]); end
            end
            rd1 += exp_q.size();
        end
        repeat (150) @(negedge clk);
        checks++; if (frames !== f0 + 2 || busy !== 1'b0) begin errors++; $display("FAIL wpass_end frames %0d busy %b want %0d 0", frames, busy, f0 + 2); end
    endtask

    task automatic test_refresh_collapse();
        bit ok;
        int n = 0;
        int f0 = frames;
        logic [8:0] got;
        pulse_refresh();
        while (cap.size() < rd1 + 5 && n < 500) begin @(negedge clk); n++; end
        pulse_refresh();
        repeat (30) @(negedge clk);
        pulse_refresh();
        repeat (30) @(negedge clk);
        pulse_refresh();
        for (int p = 0; p < 2; p++) begin
            wait_frame(f0 + 1 + p, ok);
            checks++; if (!ok) begin errors++; $display("FAIL refr_timeout%0d frames %0d", p, frames); end
            build_exp(0, 2, 16, 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                got = (rd1 + i < cap.size()) ? cap[rd1 + i] : 9'h1FF;
                checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL refr%0d_byte[%0d] got %h want %h", p, i, got, exp_q[i]); end
            end
            rd1 += exp_q.size();
        end
        repeat (150) @(negedge clk);
        checks++; if (frames !== f0 + 2 || busy !== 1'b0) begin errors++; $display("FAIL refr_count frames %0d busy %b want %0d 0", frames, busy, f0 + 2); end
        do_write(40, 8'h33);
        repeat (100) @(negedge clk);
        checks++; if (frames !== f0 + 2 || cap.size() !== rd1 || busy !== 1'b0) begin errors++; $display("FAIL oor40 frames %0d bytes %0d busy %b", frames, cap.size(), busy); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int n = 0;
        int f0;
        logic [8:0] got;
        for (int k = 0; k < 3; k++) do_write($urandom_range(0, 31), 8'($urandom_range(33, 126)));
        while (!(cap.size() >= rd1 + 4 && lstart) && n < 800) begin @(negedge clk); n++; end
        checks++; if (lstart !== 1'b1) begin errors++; $display("FAIL rstw_not_in_wait start %b want 1", lstart); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (lstart !== 1'b0) begin errors++; $display("FAIL rstw_start_async got %b want 0", lstart); end
        for (int i = 0; i < 80; i++) mbuf[i] = 8'h20;
        repeat (3) @(negedge clk);
        rd1 = cap.size();
        f0 = frames;
        rst_n = 1'b1;
        wait_frame(f0 + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstw_timeout frames %0d want %0d", frames, f0 + 1); end
        build_exp(1, 2, 16, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (rd1 + i < cap.size()) ? cap[rd1 + i] : 9'h1FF;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL rstw_byte[%0d] got %h want %h", i, got, exp_q[i]); end
        end
        rd1 += exp_q.size();
    endtask

    initial begin
        test_reset();
        test_init_pass();
        test_continuous();
        test_write_idle();
        test_random_writes();
        test_write_during_pass();
        test_refresh_collapse();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_frame_refresher.md
Name: lcd_frame_refresher

Overview:
- Parametrised successor to the fixed-text LCD content generator.
- Holds a host-writable character frame buffer of ROWS x COLS bytes and streams it to the HD44780-style LCD controller.
- Sequence: the init command set, then one set-DDRAM-address command per row, then that row's characters.
- Refresh triggers: request, buffer change, or continuous mode. Sits between the application FSM and the existing LCD controller (iStart/oDone handshake).

Parameters:
- ROWS, 2, display rows, legal range 1..4.
- COLS, 16, characters per row, legal range 8..20.
- DLY_CYCLES, 262142, idle cycles after each controller done before the next transfer.
- CONTINUOUS, 0, 1 = restart a pass immediately after every frame; 0 = refresh only on request or dirty.
- AW, 7, write-address width, must satisfy 2^AW >= ROWS*COLS.

Ports:
- iCLK in 1: clock.
- iRST_N in 1: reset, asynchronous, active-low.
- iWE in 1: buffer write strobe.
- iWADDR in AW: linear address, row*COLS+col.
- iWDATA in 8: ASCII character.
- iREFRESH in 1: one-cycle refresh request.
- oBUSY out 1: high while a pass is in progress.
- oFRAME_DONE out 1: one-cycle pulse when a pass completes.
- oLCD_DATA out 8: byte to the controller.
- oLCD_RS out 1: 0 = command, 1 = data.
- oLCD_START out 1: transfer request to the controller.
- iLCD_DONE in 1: controller transfer-complete flag.

Behaviour:
- Reset values:
  - All outputs 0.
  - Buffer filled with 0x20.
  - dirty=1, init_done=0.
  - State INIT, index 0, delay counter 0.
  - Reset mid-transfer aborts immediately; oLCD_START drops asynchronously.
- Buffer writes:
  - iWE with iWADDR < ROWS*COLS writes iWDATA on that clock edge and sets dirty.
  - Writes at or beyond ROWS*COLS are ignored and leave dirty unchanged.
  - Writes are accepted in every state.
- Transfer micro-sequence (every byte):
  - LOAD: present oLCD_DATA/oLCD_RS, assert oLCD_START.
  - WAIT: hold data until iLCD_DONE=1, then deassert oLCD_START.
  - DLY: count DLY_CYCLES cycles.
  - NEXT: advance the sequence.
  - Data and RS stay stable from LOAD through WAIT.
- Byte order of a pass:
  - INIT only, once after reset: 0x038, 0x00C, 0x001, 0x006.
  - Then, for r = 0..ROWS-1: command 0x80|base(r), then COLS data bytes (RS=1) from buffer[r*COLS .. r*COLS+COLS-1].
  - Row bases: r0=0x00, r1=0x40, r2=COLS, r3=0x40+COLS.
- Data sampling: each character is read from the buffer in its LOAD cycle. A write to a not-yet-sent address during a pass appears in that pass.
- Dirty handling:
  - dirty is cleared in the LOAD cycle of the row-0 address command.
  - A write during a pass sets dirty again, so one further pass follows.
- Top-level states:
  - INIT: 4 init commands; sets init_done, then goes to ROWCMD.
  - IDLE: oBUSY=0.
  - ROWCMD: row address command.
  - CHARS: the row's characters.
  - FIN: one cycle; pulses oFRAME_DONE.
- Transitions:
  - INIT → ROWCMD.
  - ROWCMD → CHARS after its transfer.
  - CHARS → ROWCMD of the next row, or FIN after the last character of the last row.
  - FIN → ROWCMD if (CONTINUOUS or dirty or a pending request), else IDLE.
  - IDLE → ROWCMD on (iREFRESH or dirty).
- Refresh requests: iREFRESH arriving while oBUSY=1 sets a pending flag, which FIN consumes. Multiple requests during one pass collapse into one.
- oBUSY: 1 in INIT, ROWCMD, CHARS and FIN; 0 only in IDLE.
- Controller done timing: iLCD_DONE asserted in the same cycle as oLCD_START counts as done. A done pulse seen outside WAIT is ignored.
- Counter width: the delay counter is sized by $clog2(DLY_CYCLES+1). DLY_CYCLES=0 goes straight from WAIT to NEXT.

Test Plan:
- Use a controller model that returns done 3 cycles after start, with DLY_CYCLES=4, ROWS=2, COLS=16. Release reset with no writes → bytes 0x038, 0x00C, 0x001, 0x006, 0x080, then 16× 0x120, then 0x0C0, then 16× 0x120. Exactly one oFRAME_DONE pulse follows, then IDLE with oBUSY=0.
- In IDLE, write 'A' (0x41) to addr 17 → new pass with no init bytes. The second byte after 0x0C0 is 0x141. The pass ends in IDLE.
- During a pass in row 0, write 0x5A to addr 20 → 0x15A appears in this pass. dirty causes exactly one extra pass, then IDLE.
- Pulse iREFRESH three times during one pass → exactly one additional pass. Write to addr 40 (out of range) in IDLE → no pass starts.
- ROWS=4, COLS=20, CONTINUOUS=1 → row commands 0x080, 0x0C0, 0x094, 0x0D4. Passes repeat back-to-back with oBUSY held at 1.
- Assert reset while in WAIT mid-row → oLCD_START drops immediately. After release, the sequence restarts with 0x038 and the buffer reads back all 0x20.
